block_reducer: RTL
==================

# block_reducer

Downstream consumer of the multiplier's read-back stream. It requests a block read from the product memory, accepts DEPTH = 2**LOGDEPTH product words, and reduces them to a sum, maximum and minimum. It then presents the registered result through a valid/ready handshake to the next stage. It lets the design drain the product buffer and return the multiplier to its idle state without host involvement.

## Interface
- LOGDEPTH, 6: log2 of words per block; DEPTH = 2**LOGDEPTH.
- WIDTH, 32: product word width.
- TIMEOUT, 255: max consecutive cycles without VALID_memVal in REQ/COLLECT before abort; 1..65535.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one block reduction; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- EN_blockRead  out  1  block-read request to the multiplier.
- VALID_memVal  in  1  memVal_data carries a valid product this cycle.
- memVal_data  in  WIDTH  product word.
- res_valid  out  1  result registers valid.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH+LOGDEPTH  unsigned sum of accepted words.
- res_max  out  WIDTH  unsigned maximum.
- res_min  out  WIDTH  unsigned minimum.
- res_count  out  LOGDEPTH+1  words accepted.
- res_error  out  1  block ended by timeout.

## Operation
- Reset (async assert, sync release): state IDLE; all outputs 0; internal sum, count and timeout counter 0; max 0; min all-ones.
- IDLE: start=1 → REQ. Clear sum, count, error and timeout counter; max ← 0; min ← all-ones. VALID_memVal in IDLE is ignored.
- REQ: EN_blockRead=1, held until the first VALID_memVal is sampled. That word is accumulated, and the state moves to COLLECT in the same edge. EN_blockRead is 0 in every other state.
- COLLECT: each cycle with VALID_memVal=1:
  - sum += zero-extended word; count += 1.
  - max ← word if word > max; min ← word if word < min.
  - timeout counter ← 0.
- Block end: when the word making count == DEPTH is accepted → DONE with res_error=0. Valid words after that are ignored.
- Timeout: in REQ/COLLECT, each cycle without valid increments the timeout counter. Reaching TIMEOUT → DONE with res_error=1 and partial results. With zero words accepted: res_count=0, res_max=0, res_min=all-ones, res_sum=0.
- DONE: res_valid=1; result outputs stable. res_ready=1 → IDLE next cycle, res_valid drops. A start in the same cycle is ignored.
- Arithmetic: all unsigned. res_sum width guarantees no overflow for DEPTH words of 2**WIDTH−1.
- start while busy: ignored, not queued.
- Reset mid-block: immediate return to IDLE, EN_blockRead drops asynchronously, partial results discarded.

## Timing
- start high at edge N in IDLE → EN_blockRead=1 and busy=1 from N+1.
- First valid at edge M → EN_blockRead=0 from M+1.
- DEPTH-th valid at edge K → res_valid=1 from K+1 (1-cycle latency).
- Zero-gap stream: IDLE→DONE in DEPTH+1 cycles after the REQ entry edge.
- res_valid=1 with res_ready=1 at edge D → res_valid=0, busy=0 from D+1. Earliest next start is sampled at D+1.
- Timeout: with the last valid (or REQ entry) at edge T, DONE is entered at edge T+TIMEOUT.

## Test plan
- Normal block: start, stream 1..64 back-to-back → res_sum=2080, res_max=64, res_min=1, res_count=64, res_error=0, res_valid 1 cycle after 64th word.
- Saturating data: 64 × 0xFFFFFFFF with random 0–3 cycle gaps → res_sum=0x3F_FFFFFFC0, max=min=0xFFFFFFFF, count=64.
- Handshake: hold EN_blockRead response off 10 cycles → EN_blockRead stays 1 until first valid, then 0. Hold res_ready low 20 cycles → results stable, busy=1. Pulse start during DONE → ignored.
- Timeout: 10 words (values 5), then silence → res_valid at exactly 255 cycles after 10th word, res_error=1, res_count=10, res_sum=50. Also no words at all → res_count=0, res_min=0xFFFFFFFF.
- Reset mid-COLLECT: assert rst_n low after 30 words → all outputs 0 immediately. Next block of 64 × 2 → res_sum=128 (no stale data).
- Over-delivery: 70 valid words → only first 64 reduced, extras ignored, state IDLE after handshake.

Source files
------------

// File: rtl/block_reducer.sv
// Block reducer: requests one block of product words and reduces it to sum, max, min and count.
// The result is held in registers and offered through a valid/ready handshake.
module block_reducer #(
  parameter int LOGDEPTH = 6,
  parameter int WIDTH    = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      EN_blockRead,
  input  logic                      VALID_memVal,
  input  logic [WIDTH-1:0]          memVal_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WIDTH+LOGDEPTH-1:0] res_sum,
  output logic [WIDTH-1:0]          res_max,
  output logic [WIDTH-1:0]          res_min,
  output logic [LOGDEPTH:0]         res_count,
  output logic                      res_error
);

  localparam int SW = WIDTH + LOGDEPTH;
  localparam int CW = LOGDEPTH + 1;
  localparam int TW = 16;
  localparam logic [CW-1:0] DEPTH_C  = CW'(2 ** LOGDEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   acc_sum, sum_nxt;
  logic [WIDTH-1:0] acc_max, max_nxt, acc_min, min_nxt;
  logic [CW-1:0]   acc_count, count_nxt;
  logic [TW-1:0]   tmo_count, tmo_nxt;
  logic            accept, tmo_hit, collecting;

  // Next-state and accumulator update logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tmo_hit   = 1'b0;
    sum_nxt   = acc_sum;
    max_nxt   = acc_max;
    min_nxt   = acc_min;
    count_nxt = acc_count;
    tmo_nxt   = tmo_count;

    collecting = (state == S_REQ) || (state == S_COLLECT);
    accept     = collecting && VALID_memVal;

    if (accept) begin
      sum_nxt   = acc_sum + SW'(memVal_data);
      count_nxt = acc_count + CW'(1);
      tmo_nxt   = '0;
      if (memVal_data > acc_max) max_nxt = memVal_data;
      else                       max_nxt = acc_max;
      if (memVal_data < acc_min) min_nxt = memVal_data;
      else                       min_nxt = acc_min;
    end else if (collecting) begin
      tmo_nxt = tmo_count + TW'(1);
    end else begin
      tmo_nxt = tmo_count;
    end

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_REQ;
        else       state_nxt = S_IDLE;
      end
      S_REQ, S_COLLECT: begin
        if (accept) begin
          if (count_nxt == DEPTH_C) state_nxt = S_DONE;
          else                      state_nxt = S_COLLECT;
        end else if (tmo_count == TMO_LAST) begin
          // silence has lasted TIMEOUT cycles: give up with partial results
          state_nxt = S_DONE;
          tmo_hit   = 1'b1;
        end else begin
          state_nxt = state;
        end
      end
      S_DONE: begin
        if (res_ready) state_nxt = S_IDLE;
        else           state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      EN_blockRead <= 1'b0;
      res_valid    <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != S_IDLE);
      EN_blockRead <= (state_nxt == S_REQ);
      res_valid    <= (state_nxt == S_DONE);
    end
  end

  // Accumulators: cleared on an accepted start, otherwise follow the update logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum   <= '0;
      acc_max   <= '0;
      acc_min   <= {WIDTH{1'b1}};
      acc_count <= '0;
      tmo_count <= '0;
    end else if (state == S_IDLE && start) begin
      acc_sum   <= '0;
      acc_max   <= '0;
      acc_min   <= {WIDTH{1'b1}};
      acc_count <= '0;
      tmo_count <= '0;
    end else begin
      acc_sum   <= sum_nxt;
      acc_max   <= max_nxt;
      acc_min   <= min_nxt;
      acc_count <= count_nxt;
      tmo_count <= tmo_nxt;
    end
  end

  // Result registers capture the final accumulator values on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum   <= '0;
      res_max   <= '0;
      res_min   <= '0;
      res_count <= '0;
      res_error <= 1'b0;
    end else if (state != S_DONE && state_nxt == S_DONE) begin
      res_sum   <= sum_nxt;
      res_max   <= max_nxt;
      res_min   <= min_nxt;
      res_count <= count_nxt;
      res_error <= tmo_hit;
    end else if (state == S_IDLE && start) begin
      res_error <= 1'b0;
    end else begin
      res_error <= res_error;
    end
  end

endmodule
